// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_pkg
//  Description : Shared encodings, FSM state type and request legality check
//                for the load/store initiator.
//  Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RMW_RD = 3'd2,
    WRITE  = 3'd3,
    RESP   = 3'd4
  } lsu_state_e;

  // 1 when the request must be rejected: misaligned, illegal size or
  // word index beyond the end of the data memory.
  function automatic logic lsu_req_err(input logic [1:0]  size,
                                       input logic [31:0] addr,
                                       input int unsigned dm_words);
    logic bad_align;
    case (size)
      SZ_BYTE: bad_align = 1'b0;
      SZ_HALF: bad_align = addr[0];
      SZ_WORD: bad_align = (addr[1:0] != 2'b00);
      default: bad_align = 1'b1;
    endcase
    return bad_align | ({2'b00, addr[31:2]} >= dm_words);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_byte_lane.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_byte_lane
//  Description : Little-endian lane steering. Extracts and extends the loaded
//                lane, and merges the store lane into a read-back word.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane select, extension for loads and lane replacement for stores.
  always_comb begin
    w_byte  = rdata_i[{lane_i, 3'b000} +: 8];
    w_half  = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    load_o  = rdata_i;
    merge_o = wdata_i;
    case (size_i)
      SZ_BYTE: begin
        load_o  = {{24{signed_i & w_byte[7]}}, w_byte};
        merge_o = rdata_i;
        merge_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
      end
      SZ_HALF: begin
        load_o  = {{16{signed_i & w_half[15]}}, w_half};
        merge_o = rdata_i;
        merge_o[{lane_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lsu_dm_master.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_dm_master
//  Description : Single-outstanding load/store initiator. Turns byte, half
//                and word requests into aligned word accesses on the data
//                memory port, using read-modify-write for sub-word stores.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_dm_master
  import lsu_pkg::*;
#(
  parameter int unsigned DM_WORDS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_signed_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic [31:0] dm_addr_o,
  output logic [31:0] dm_wdata_o,
  output logic        dm_we_o,
  input  logic [31:0] dm_rdata_i
);

  lsu_state_e  r_state;
  lsu_state_e  w_next;
  logic [1:0]  r_size;
  logic        r_signed;
  logic [1:0]  r_lane;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [31:0] r_dm_addr;
  logic [31:0] r_dm_wdata;
  logic        w_accept;
  logic        w_req_err;
  logic [31:0] w_load_data;
  logic [31:0] w_merge_data;

  assign w_req_err = lsu_req_err(req_size_i, req_addr_i, DM_WORDS);
  assign w_accept  = req_valid_i & req_ready_o;

  lsu_byte_lane u_lane (
    .size_i   (r_size),
    .signed_i (r_signed),
    .lane_i   (r_lane),
    .rdata_i  (dm_rdata_i),
    .wdata_i  (r_wdata),
    .load_o   (w_load_data),
    .merge_o  (w_merge_data)
  );

  // State register; reset forces IDLE immediately so dm_we_o drops at once.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode plus the state-decoded (Moore) handshake and DM strobe.
  always_comb begin
    w_next       = r_state;
    req_ready_o  = 1'b0;
    resp_valid_o = 1'b0;
    dm_we_o      = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          if (w_req_err)                w_next = RESP;
          else if (!req_we_i)           w_next = LOAD;
          else if (req_size_i == SZ_WORD) w_next = WRITE;
          else                          w_next = RMW_RD;
        end
      end
      LOAD:    w_next = RESP;
      RMW_RD:  w_next = WRITE;
      WRITE: begin
        dm_we_o = 1'b1;
        w_next  = RESP;
      end
      RESP: begin
        resp_valid_o = 1'b1;
        w_next       = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Request latch and datapath; DM address/data registers only move for
  // legal requests so rejected ones leave the DM port untouched.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_size     <= 2'b00;
      r_signed   <= 1'b0;
      r_lane     <= 2'b00;
      r_wdata    <= 32'd0;
      r_rdata    <= 32'd0;
      r_err      <= 1'b0;
      r_dm_addr  <= 32'd0;
      r_dm_wdata <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_size   <= req_size_i;
            r_signed <= req_signed_i;
            r_lane   <= req_addr_i[1:0];
            r_wdata  <= req_wdata_i;
            r_rdata  <= 32'd0;
            r_err    <= w_req_err;
            if (!w_req_err) begin
              r_dm_addr <= {req_addr_i[31:2], 2'b00};
              if (req_we_i && (req_size_i == SZ_WORD))
                r_dm_wdata <= req_wdata_i;
            end
          end
        end
        LOAD:    r_rdata    <= w_load_data;
        RMW_RD:  r_dm_wdata <= w_merge_data;
        default: ;
      endcase
    end
  end

  assign resp_rdata_o = r_rdata;
  assign resp_err_o   = r_err;
  assign dm_addr_o    = r_dm_addr;
  assign dm_wdata_o   = r_dm_wdata;

endmodule
`default_nettype wire

// File: tb/tb_lsu_dm_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lsu_dm_master
//  Description : Scoreboard bench for lsu_dm_master with a simple DM model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_dm_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_we;
  logic [31:0] dm_rdata;

  logic [31:0] mem [32];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nwr;
    logic [31:0] waddr;
    int          acc;
  } exp_t;

  exp_t expq[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   wr_cnt = 0;
  logic [31:0] wr_addr = 32'd0;

  lsu_dm_master #(.DM_WORDS(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_we_i     (req_we),
    .req_size_i   (req_size),
    .req_signed_i (req_signed),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .resp_valid_o (resp_valid),
    .resp_rdata_o (resp_rdata),
    .resp_err_o   (resp_err),
    .dm_addr_o    (dm_addr),
    .dm_wdata_o   (dm_wdata),
    .dm_we_o      (dm_we),
    .dm_rdata_i   (dm_rdata)
  );

  always #5 clk = ~clk;

  // Data memory model: combinational read, write on posedge.
  assign dm_rdata = mem[dm_addr[6:2]];
  always @(posedge clk) if (dm_we) mem[dm_addr[6:2]] <= dm_wdata;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: counts DM writes and checks each response against the scoreboard.
  always @(negedge clk) begin
    if (dm_we) begin
      wr_cnt  = wr_cnt + 1;
      wr_addr = dm_addr;
    end
    if (resp_valid) begin
      if (expq.size() == 0) begin
        chk("unexpected_resp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = expq.pop_front();
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
        chk("resp_latency", 32'(cyc - e.acc + 1), 32'(e.lat));
        chk("dm_write_count", 32'(wr_cnt), 32'(e.nwr));
        if (e.nwr > 0) chk("dm_write_addr", wr_addr, e.waddr);
        chk("ready_in_resp", {31'd0, req_ready}, 32'd0);
      end
      wr_cnt = 0;
    end
  end

  // Present a request, wait (bounded) for acceptance, push expected response.
  task automatic issue(input logic we, input logic [1:0] sz, input logic sg,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rd, input logic exp_err,
                       input int lat, input int nwr, input int exp_wait,
                       input logic push);
    int   waits;
    int   acc;
    logic done;
    exp_t e;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
    req_addr = addr; req_wdata = wdata;
    waits = 0; done = 1'b0; acc = 0;
    while (!done && waits < 50) begin
      if (req_ready) begin
        acc = cyc + 1;
        @(posedge clk);
        done = 1'b1;
      end else begin
        waits++;
        @(negedge clk);
      end
    end
    if (!done) chk("accept_timeout", 32'd1, 32'd0);
    else begin
      if (exp_wait >= 0) chk("ready_wait", 32'(waits), 32'(exp_wait));
      if (push) begin
        e.rdata = exp_rd; e.err = exp_err; e.lat = lat; e.nwr = nwr;
        e.waddr = {addr[31:2], 2'b00}; e.acc = acc;
        expq.push_back(e);
      end
    end
  endtask

  task automatic drain();
    int n;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (expq.size() != 0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (expq.size() != 0) chk("drain_timeout", 32'(expq.size()), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_dm_we", {31'd0, dm_we}, 32'd0);
    chk("rst_dm_addr", dm_addr, 32'd0);
    chk("rst_dm_wdata", dm_wdata, 32'd0);
    @(negedge clk); rst_n = 1'b0;
    #1 chk("rst_ready", {31'd0, req_ready}, 32'd1);

    // Word store
    issue(1, 2'b10, 0, 32'h8, 32'hDEADBEEF, 32'd0, 0, 2, 1, 0, 1);
    drain();
    chk("mem2_word_store", mem[2], 32'hDEADBEEF);

    // Byte store read-modify-write into lane 2
    issue(1, 2'b10, 0, 32'h8, 32'h11223344, 32'd0, 0, 2, 1, 0, 1);
    issue(1, 2'b00, 0, 32'hA, 32'h000000AB, 32'd0, 0, 3, 1, 2, 1);
    drain();
    chk("mem2_byte_store", mem[2], 32'h11AB3344);

    // Loads, held back-to-back
    issue(1, 2'b10, 0, 32'h8, 32'h80FF7F01, 32'd0, 0, 2, 1, 0, 1);
    issue(0, 2'b00, 1, 32'h9, 32'd0, 32'h0000007F, 0, 2, 0, 2, 1);
    issue(0, 2'b00, 0, 32'hB, 32'd0, 32'h00000080, 0, 2, 0, 2, 1);
    issue(0, 2'b01, 1, 32'hA, 32'd0, 32'hFFFF80FF, 0, 2, 0, 2, 1);
    issue(0, 2'b01, 0, 32'h8, 32'd0, 32'h00007F01, 0, 2, 0, 2, 1);
    issue(0, 2'b00, 1, 32'hA, 32'd0, 32'hFFFFFFFF, 0, 2, 0, 2, 1);
    issue(0, 2'b10, 1, 32'h8, 32'd0, 32'h80FF7F01, 0, 2, 0, 2, 1);
    drain();

    // Rejected requests
    issue(0, 2'b01, 1, 32'h5,  32'd0,        32'd0, 1, 1, 0, 0, 1);
    issue(1, 2'b10, 0, 32'h80, 32'h12345678, 32'd0, 1, 1, 0, 1, 1);
    issue(1, 2'b11, 0, 32'h8,  32'h12345678, 32'd0, 1, 1, 0, 1, 1);
    issue(0, 2'b00, 0, 32'h81, 32'd0,        32'd0, 1, 1, 0, 1, 1);
    issue(1, 2'b10, 0, 32'h6,  32'h12345678, 32'd0, 1, 1, 0, 1, 1);
    drain();
    chk("mem2_after_errors", mem[2], 32'h80FF7F01);

    // Last legal word and half-word store
    issue(1, 2'b10, 0, 32'h7C, 32'hCAFEF00D, 32'd0, 0, 2, 1, 0, 1);
    issue(0, 2'b10, 0, 32'h7C, 32'd0, 32'hCAFEF00D, 0, 2, 0, 2, 1);
    issue(1, 2'b10, 0, 32'h4, 32'hAAAAAAAA, 32'd0, 0, 2, 1, 2, 1);
    issue(1, 2'b01, 0, 32'h6, 32'h12345678, 32'd0, 0, 3, 1, 2, 1);
    issue(0, 2'b01, 1, 32'h6, 32'd0, 32'h00005678, 0, 2, 0, 3, 1);
    drain();
    chk("mem1_half_store", mem[1], 32'h5678AAAA);

    // Reset during RMW_RD of a byte store
    issue(1, 2'b00, 0, 32'h8, 32'h00000055, 32'd0, 0, 3, 1, 0, 0);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("midrst_dm_we", {31'd0, dm_we}, 32'd0);
    chk("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1 chk("midrst_ready", {31'd0, req_ready}, 32'd1);
    chk("midrst_no_write", mem[2], 32'h80FF7F01);
    issue(0, 2'b10, 0, 32'h8, 32'd0, 32'h80FF7F01, 0, 2, 0, 0, 1);
    drain();
    chk("final_queue_empty", 32'(expq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lsu_dm_master.md
Name: lsu_dm_master

Overview:
- Load/store initiator between the single-cycle CPU datapath and the word-addressed data memory.
- Accepts one byte, halfword or word request at a time over a valid/ready handshake.
- Does aligned word accesses on the DM port. Sub-word stores use read-modify-write; loads use lane extraction with sign or zero extension.
- Returns one response pulse per request. Misaligned or out-of-range requests are flagged and never touch the DM.

Parameters:
- DM_WORDS, 32, number of 32-bit words in the DM; word index = addr[31:2]; legal when index < DM_WORDS.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-high.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  block can accept a request.
- req_we_i  in  1  1 = store, 0 = load.
- req_size_i  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_signed_i  in  1  loads: 1 = sign-extend, 0 = zero-extend.
- req_addr_i  in  32  byte address.
- req_wdata_i  in  32  store data, right-justified.
- resp_valid_o  out  1  one-cycle response pulse.
- resp_rdata_o  out  32  load result; 0 for stores and errors.
- resp_err_o  out  1  misaligned, illegal size or out of range.
- dm_addr_o  out  32  DM byte address, always {word_index, 2'b00}.
- dm_wdata_o  out  32  DM write data.
- dm_we_o  out  1  DM write enable; DM writes on posedge while high.
- dm_rdata_i  in  32  DM combinational read data for dm_addr_o.

Behaviour:
- Reset (async, rst_n=1):
  - state IDLE.
  - Outputs: req_ready_o=1 once reset is released; resp_valid_o=0, resp_err_o=0, resp_rdata_o=0, dm_we_o=0, dm_addr_o=0, dm_wdata_o=0.
  - All latched request fields cleared.
- Handshake:
  - Accept when req_valid_i & req_ready_o at posedge.
  - req_ready_o=1 only in IDLE. No request is queued; a request held during a busy period is accepted on return to IDLE.
- Error check on accept:
  - half needs addr[0]=0; word needs addr[1:0]=0; size 11 is illegal; index >= DM_WORDS is out of range.
  - Any failure: next state RESP with err=1, rdata=0, no DM cycle.
- States:
  - IDLE -> LOAD (load), WRITE (word store), RMW_RD (byte/half store), RESP (error).
  - LOAD: drive dm_addr_o, capture extended lane of dm_rdata_i -> RESP.
  - RMW_RD: drive dm_addr_o, capture dm_rdata_i into a merge buffer -> WRITE.
  - WRITE: dm_we_o=1 for exactly this cycle; dm_wdata_o = word (word store) or merge buffer with target lane replaced -> RESP.
  - RESP: resp_valid_o=1 for one cycle -> IDLE.
- Latency, accept edge = cycle 0, resp_valid_o high during:
  - cycle 2 for load and word store;
  - cycle 3 for sub-word store;
  - cycle 1 for error.
- Back-to-back: a new request is accepted in the cycle after RESP (IDLE). Throughput is 1 request per 3 or 4 cycles.
- Lanes: little-endian.
  - Byte lane = addr[1:0] (bits 8*k+7:8*k).
  - Half lane = addr[1] (bits 16*h+15:16*h).
  - Store uses the low byte/half of req_wdata_i.
- dm_we_o is state-decoded (Moore) and never high outside WRITE. dm_addr_o and dm_wdata_o hold their last values in IDLE/RESP.
- Reset mid-operation: state returns to IDLE immediately. dm_we_o drops asynchronously. No response is issued and no DM write occurs unless the posedge with dm_we_o=1 has already passed.
- The only DM traffic is one read and/or one write per legal request; loads never assert dm_we_o.

Decomposition:
- Package lsu_pkg: size encodings (SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10), state enum (IDLE, LOAD, RMW_RD, WRITE, RESP), error-check function.
- Sub-module lsu_byte_lane: combinational load extract/extend and store merge, driven by size, signed and addr[1:0].
- The FSM and registers stay in lsu_dm_master.

Test Plan:
- Word store addr=0x8, data=0xDEADBEEF -> dm_we_o high exactly cycle 1, dm_addr_o=0x8; resp_valid_o at cycle 2, err=0; DM word 2 = 0xDEADBEEF.
- DM word 2=0x11223344, byte store addr=0xA, data=0xAB -> one read at cycle 1, write at cycle 2 of 0x11AB3344; resp at cycle 3.
- DM word 2=0x80FF7F01: signed byte load addr=0x9 -> rdata 0x0000007F; unsigned byte load addr=0xB -> 0x00000080; signed half load addr=0xA -> 0xFFFF80FF.
- Half load addr=0x5 and word store addr=0x80 (index 32) -> resp at cycle 1, err=1, rdata=0, dm_we_o never high, DM unchanged.
- req_valid_i held high with 3 queued requests -> req_ready_o low from cycle 1 until IDLE; each request is accepted exactly once, in order.
- rst_n asserted during RMW_RD of a byte store -> no write, no resp, state IDLE; after release req_ready_o=1 and the next request completes normally.
